exc_controller: RTL and testbench

//   Upstream feeder of the exception unit. Collects exception sources from the pipeline:
//     - invalid opcode (decode)
//     - misaligned access (mem)
//     - external interrupt (level)

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_pending.sv | 53 +++++
 rtl/exc_controller.sv | 110 +++++++++++
 tb/tb_exc_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception request path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [3:0] ESTAT_INVOP    = 4'b0001;
    localparam logic [3:0] ESTAT_MISALIGN = 4'b0010;
    localparam logic [3:0] ESTAT_IRQ      = 4'b0100;

    // Fetch address the exception unit vectors to.
    localparam logic [63:0] EXC_VECTOR = 64'hD8;

    // Pending bit positions.
    localparam int PEND_INVOP    = 0;
    localparam int PEND_MISALIGN = 1;
    localparam int PEND_IRQ      = 2;

endpackage

// File: rtl/exc_pending.sv
// Sticky pending bits for the three exception sources plus fixed-priority select.
// Latency: a source seen at edge t is visible on any/sel_code right after edge t.
// Backpressure: bits stay pending until clr_en; a set coincident with a clear wins.
//
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   set_vec[2:0]  {irq (already gated by irq_en), misalign, invalid_op}
//   clr_en        consume the currently selected bit at this edge
//   any           at least one bit pending
//   sel_code      cause code of the highest-priority pending bit
//   clr_mask      one-hot mask of that bit
module exc_pending
    import exc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] set_vec,
    input  logic       clr_en,
    output logic       any,
    output logic [3:0] sel_code,
    output logic [2:0] clr_mask
);

    logic [2:0] pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= 3'b000;
        end else begin
            // OR the set after the clear so an event arriving on the clear edge re-pends.
            pend <= (pend & ~(clr_mask & {3{clr_en}})) | set_vec;
        end
    end

    // invalid_op > misalign > irq
    always_comb begin
        clr_mask = 3'b000;
        sel_code = 4'h0;
        if (pend[PEND_INVOP]) begin
            clr_mask = 3'b001;
            sel_code = ESTAT_INVOP;
        end else if (pend[PEND_MISALIGN]) begin
            clr_mask = 3'b010;
            sel_code = ESTAT_MISALIGN;
        end else if (pend[PEND_IRQ]) begin
            clr_mask = 3'b100;
            sel_code = ESTAT_IRQ;
        end
    end

    assign any = |pend;

endmodule

// File: rtl/exc_controller.sv
// Collects exception sources, issues one request at a time to the exception unit.
// Latency: source pulse at edge t -> pending at t -> Exc=1 after edge t+1.
// Backpressure: Exc held until ExcAck; no new request until ERet; events keep pending meanwhile.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   invalid_op, misalign one-cycle source pulses
//   irq, irq_en          level interrupt and its enable
//   ExcAck, ERet         exception unit has vectored / handler returned
//   Exc, EStatus         request and its cause code (registered)
//   busy                 request outstanding or handler running
//   exc_count            saturating count of acknowledged exceptions
//   ack_timeout          sticky: Exc waited ACK_TIMEOUT cycles without ExcAck
module exc_controller
    import exc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             invalid_op,
    input  logic             misalign,
    input  logic             irq,
    input  logic             irq_en,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic             busy,
    output logic [CNT_W-1:0] exc_count,
    output logic             ack_timeout
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    exc_state_t       state;
    logic [TMR_W-1:0] timer;

    logic       any;
    logic [3:0] sel_code;
    logic [2:0] clr_mask;
    logic       issue;

    assign issue = (state == IDLE) && any;

    exc_pending u_pend (
        .clk      (clk),
        .reset    (reset),
        .set_vec  ({irq & irq_en, misalign, invalid_op}),
        .clr_en   (issue),
        .any      (any),
        .sel_code (sel_code),
        .clr_mask (clr_mask)
    );

    // Exc/busy are registered alongside the state so they carry no input-to-output path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            Exc         <= 1'b0;
            busy        <= 1'b0;
            EStatus     <= 4'h0;
            exc_count   <= '0;
            ack_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= REQ;
                        Exc     <= 1'b1;
                        busy    <= 1'b1;
                        EStatus <= sel_code;
                    end
                end
                REQ: begin
                    if (ExcAck) begin
                        state <= HANDLER;
                        Exc   <= 1'b0;
                        timer <= '0;
                        if (exc_count != CNT_MAX) begin
                            exc_count <= exc_count + 1'b1;
                        end
                    end else if (timer == TMR_LAST) begin
                        // Timer parks here; the request stays up for a late ack.
                        ack_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HANDLER: begin
                    if (ERet) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Exc   <= 1'b0;
                    busy  <= 1'b0;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_controller.sv
module tb_exc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       invalid_op, misalign, irq, irq_en, ExcAck, ERet;
    logic       Exc, busy, ack_timeout;
    logic [3:0] EStatus;
    logic [7:0] exc_count;
    logic       Exc_s, busy_s, ack_timeout_s;
    logic [3:0] EStatus_s;
    logic [1:0] exc_count_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exc_controller #(.ACK_TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .invalid_op(invalid_op), .misalign(misalign),
        .irq(irq), .irq_en(irq_en), .ExcAck(ExcAck), .ERet(ERet),
        .Exc(Exc), .EStatus(EStatus), .busy(busy),
        .exc_count(exc_count), .ack_timeout(ack_timeout)
    );

    exc_controller #(.ACK_TIMEOUT(16), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .invalid_op(invalid_op), .misalign(misalign),
        .irq(irq), .irq_en(irq_en), .ExcAck(ExcAck), .ERet(ERet),
        .Exc(Exc_s), .EStatus(EStatus_s), .busy(busy_s),
        .exc_count(exc_count_s), .ack_timeout(ack_timeout_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_invop();
        invalid_op = 1'b1; tick(); invalid_op = 1'b0;
    endtask

    task automatic ack();
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
    endtask

    task automatic eret();
        ERet = 1'b1; tick(); ERet = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; invalid_op = 1'b0; misalign = 1'b0; irq = 1'b0;
        irq_en = 1'b0; ExcAck = 1'b0; ERet = 1'b0;

        // 1. reset then idle
        tick(2);
        chk("rst_exc", 32'(Exc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_estatus", 32'(EStatus), 0);
        chk("rst_count", 32'(exc_count), 0);
        chk("rst_timeout", 32'(ack_timeout), 0);
        reset = 1'b1;
        tick(10);
        chk("idle_exc", 32'(Exc), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_estatus", 32'(EStatus), 0);

        // 2. single cause
        pulse_invop();
        chk("t2_pending_only", 32'(Exc), 0);
        tick();
        chk("t2_exc", 32'(Exc), 1);
        chk("t2_estatus", 32'(EStatus), 4'b0001);
        chk("t2_busy_req", 32'(busy), 1);
        tick();
        ack();
        chk("t2_exc_after_ack", 32'(Exc), 0);
        chk("t2_busy_handler", 32'(busy), 1);
        chk("t2_count", 32'(exc_count), 1);
        tick(3);
        chk("t2_no_reissue", 32'(Exc), 0);
        eret();
        chk("t2_busy_after_eret", 32'(busy), 0);
        chk("t2_estatus_held", 32'(EStatus), 4'b0001);

        // 3. priority and queuing
        do_reset();
        irq_en = 1'b1;
        invalid_op = 1'b1; misalign = 1'b1; irq = 1'b1;
        tick();
        invalid_op = 1'b0; misalign = 1'b0;
        tick();
        chk("t3_first", 32'(EStatus), 4'b0001);
        chk("t3_first_exc", 32'(Exc), 1);
        ack(); eret();
        chk("t3_idle1", 32'(Exc), 0);
        tick();
        chk("t3_second", 32'(EStatus), 4'b0010);
        chk("t3_second_exc", 32'(Exc), 1);
        ack(); eret();
        irq = 1'b0;
        tick();
        chk("t3_third", 32'(EStatus), 4'b0100);
        chk("t3_third_exc", 32'(Exc), 1);
        ack(); eret();
        tick(2);
        chk("t3_drained", 32'(Exc), 0);
        chk("t3_count", 32'(exc_count), 3);

        // 4. masking and events during the handler
        irq_en = 1'b0; irq = 1'b1;
        tick(20);
        chk("t4_masked_exc", 32'(Exc), 0);
        chk("t4_masked_busy", 32'(busy), 0);
        irq = 1'b0;
        pulse_invop(); tick(); ack();
        misalign = 1'b1; tick(); misalign = 1'b0;
        tick(2);
        chk("t4_handler_hold", 32'(Exc), 0);
        chk("t4_handler_busy", 32'(busy), 1);
        eret();
        chk("t4_eret_idle", 32'(Exc), 0);
        tick();
        chk("t4_after_eret", 32'(Exc), 1);
        chk("t4_after_eret_code", 32'(EStatus), 4'b0010);
        ack(); eret();
        // misalign held across the edge that consumes it: the bit re-pends.
        misalign = 1'b1; tick(2); misalign = 1'b0;
        chk("t4_repend_first", 32'(EStatus), 4'b0010);
        ack(); eret(); tick();
        chk("t4_repend_second", 32'(Exc), 1);
        chk("t4_repend_code", 32'(EStatus), 4'b0010);
        ack(); eret();

        // 5. ack timeout
        do_reset();
        pulse_invop(); tick();
        chk("t5_exc_rise", 32'(Exc), 1);
        tick(15);
        chk("t5_not_yet", 32'(ack_timeout), 0);
        tick();
        chk("t5_timeout", 32'(ack_timeout), 1);
        chk("t5_exc_held", 32'(Exc), 1);
        tick(3);
        ack();
        chk("t5_late_ack_exc", 32'(Exc), 0);
        chk("t5_late_ack_busy", 32'(busy), 1);
        chk("t5_sticky", 32'(ack_timeout), 1);
        eret();

        // 6. reset mid-handler and counter saturation
        pulse_invop(); tick(); ack();
        irq_en = 1'b1; invalid_op = 1'b1; misalign = 1'b1; irq = 1'b1;
        tick();
        invalid_op = 1'b0; misalign = 1'b0; irq = 1'b0; irq_en = 1'b0;
        do_reset();
        chk("t6_rst_exc", 32'(Exc), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_estatus", 32'(EStatus), 0);
        chk("t6_rst_count", 32'(exc_count), 0);
        chk("t6_rst_timeout", 32'(ack_timeout), 0);
        tick(5);
        chk("t6_discarded", 32'(Exc), 0);
        for (int k = 0; k < 5; k++) begin
            pulse_invop(); tick(); ack(); eret();
        end
        chk("t6_count_wide", 32'(exc_count), 5);
        chk("t6_count_sat", 32'(exc_count_s), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
